// File: rtl/store_write_buffer.sv
// store_write_buffer: write-combining buffer between the store queue and dcache.
// Merges committed stores into word entries, drains them oldest-first, and
// forwards undrained bytes to loads.
// Ports:
//   clock, reset           clock; synchronous active-low reset
//   sq_dcache_packet[i]    {valid, addr[31:0], sign_size[2:0], data[31:0]}
//                          sign_size[1:0]: 0=BYTE 1=HALF 2=WORD
//   dcache_accept[i]       per-port accept (combinational)
//   mem_req_*, mem_ack     dcache write request / consume handshake
//   lq_addr, fwd_mask/data load forwarding lookup (combinational)
//   empty                  no entries and no request outstanding
module store_write_buffer #(
  parameter int NUM_SQ_DCACHE = 2,
  parameter int WB_LEN = 4,
  parameter int NUM_FU_LOAD = 2,
  localparam int PKT_W = 68,
  localparam int PW = $clog2(WB_LEN)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_SQ_DCACHE-1:0][PKT_W-1:0] sq_dcache_packet,
  output logic [NUM_SQ_DCACHE-1:0]            dcache_accept,
  output logic                                mem_req_valid,
  output logic [31:0]                         mem_req_addr,
  output logic [31:0]                         mem_req_data,
  output logic [3:0]                          mem_req_mask,
  input  logic                                mem_ack,
  input  logic [NUM_FU_LOAD-1:0][31:0]        lq_addr,
  output logic [NUM_FU_LOAD-1:0][3:0]         fwd_mask,
  output logic [NUM_FU_LOAD-1:0][31:0]        fwd_data,
  output logic                                empty
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                    state;
  logic [WB_LEN-1:0]         ent_valid;
  logic [WB_LEN-1:0]         ent_locked;
  logic [WB_LEN-1:0][29:0]   ent_word;
  logic [WB_LEN-1:0][3:0]    ent_mask;
  logic [WB_LEN-1:0][31:0]   ent_data;
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [PW:0]               count;

  logic [WB_LEN-1:0]         n_valid;
  logic [WB_LEN-1:0][29:0]   n_word;
  logic [WB_LEN-1:0][3:0]    n_mask;
  logic [WB_LEN-1:0][31:0]   n_data;
  logic [NUM_SQ_DCACHE-1:0]  acc;
  logic [PW:0]               alloc_cnt;
  logic                      pop;

  logic [NUM_SQ_DCACHE-1:0]          p_alloc;
  logic [NUM_SQ_DCACHE-1:0][PW-1:0]  p_slot;
  logic [NUM_SQ_DCACHE-1:0][29:0]    p_word;
  logic                      blocked;
  logic                      hit;
  logic [PW-1:0]             hidx;
  logic                      pv;
  logic [31:0]               pa;
  logic [1:0]                ps;
  logic [31:0]               pd;
  logic [3:0]                lm;
  logic [31:0]               ld;
  logic [PW-1:0]             fidx;
  logic                      unused_bits;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (1'b1)
      (sz == 2'd0): m = 4'b0001 << a;
      (sz == 2'd1): m = a[1] ? 4'b1100 : 4'b0011;
      default:      m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  sz,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      (sz == 2'd0): r = {24'b0, d[7:0]} << {a, 3'b000};
      (sz == 2'd1): r = a[1] ? {d[15:0], 16'b0} : {16'b0, d[15:0]};
      default:      r = d;
    endcase
    return r;
  endfunction

  // Ports are resolved in index order against the current state; a port
  // that cannot be placed blocks every younger port this cycle.
  always_comb begin
    n_valid   = ent_valid;
    n_word    = ent_word;
    n_mask    = ent_mask;
    n_data    = ent_data;
    acc       = '0;
    alloc_cnt = '0;
    p_alloc   = '0;
    p_slot    = '0;
    p_word    = '0;
    blocked   = 1'b0;
    hit       = 1'b0;
    hidx      = '0;
    pv        = 1'b0;
    pa        = '0;
    ps        = '0;
    pd        = '0;
    lm        = '0;
    ld        = '0;
    for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
      pv        = sq_dcache_packet[i][67];
      pa        = sq_dcache_packet[i][66:35];
      ps        = sq_dcache_packet[i][33:32];
      pd        = sq_dcache_packet[i][31:0];
      lm        = lane_mask(ps, pa[1:0]);
      ld        = lane_data(ps, pa[1:0], pd);
      p_word[i] = pa[31:2];
      hit       = 1'b0;
      hidx      = '0;
      if (pv && !blocked) begin
        for (int e = 0; e < WB_LEN; e++) begin
          if (ent_valid[e] && !ent_locked[e] &&
              ent_word[e] == pa[31:2]) begin
            hit  = 1'b1;
            hidx = PW'(e);
          end
        end
        for (int j = 0; j < NUM_SQ_DCACHE; j++) begin
          if (j < i && acc[j] && p_alloc[j] &&
              p_word[j] == pa[31:2]) begin
            hit  = 1'b1;
            hidx = p_slot[j];
          end
        end
        if (hit) begin
          acc[i] = 1'b1;
        end else if (({1'b0, count} + {1'b0, alloc_cnt}) <
                     (PW+2)'(WB_LEN)) begin
          acc[i]       = 1'b1;
          hidx         = tail + alloc_cnt[PW-1:0];
          p_alloc[i]   = 1'b1;
          p_slot[i]    = hidx;
          alloc_cnt    = alloc_cnt + 1'b1;
          n_valid[hidx] = 1'b1;
          n_word[hidx]  = pa[31:2];
          n_mask[hidx]  = 4'b0000;
          n_data[hidx]  = '0;
        end else begin
          blocked = 1'b1;
        end
        if (acc[i]) begin
          n_mask[hidx] = n_mask[hidx] | lm;
          for (int b = 0; b < 4; b++) begin
            if (lm[b]) n_data[hidx][8*b +: 8] = ld[8*b +: 8];
          end
        end
      end
    end
  end

  assign dcache_accept = acc & {NUM_SQ_DCACHE{reset}};
  assign pop   = (state == REQ) && mem_ack;
  assign empty = (count == '0) && !mem_req_valid;

  // Youngest matching entry wins per byte; valid entries are contiguous
  // from head, so walking from head gives oldest-to-youngest order.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    fidx     = '0;
    for (int l = 0; l < NUM_FU_LOAD; l++) begin
      for (int k = 0; k < WB_LEN; k++) begin
        fidx = head + PW'(k);
        if (ent_valid[fidx] && ent_word[fidx] == lq_addr[l][31:2]) begin
          fwd_mask[l] = fwd_mask[l] | ent_mask[fidx];
          for (int b = 0; b < 4; b++) begin
            if (ent_mask[fidx][b])
              fwd_data[l][8*b +: 8] = ent_data[fidx][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < NUM_SQ_DCACHE; i++)
      unused_bits = unused_bits ^ sq_dcache_packet[i][34];
    for (int l = 0; l < NUM_FU_LOAD; l++)
      unused_bits = unused_bits ^ (^lq_addr[l][1:0]);
  end

  // The head request is loaded from the post-merge view so a store that
  // merges into the head in the locking cycle is not lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      ent_valid     <= '0;
      ent_locked    <= '0;
      ent_word      <= '0;
      ent_mask      <= '0;
      ent_data      <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_mask  <= '0;
    end else begin
      ent_valid <= n_valid;
      ent_word  <= n_word;
      ent_mask  <= n_mask;
      ent_data  <= n_data;
      tail      <= tail + alloc_cnt[PW-1:0];
      count     <= count + alloc_cnt - (PW+1)'(pop);
      unique case (state)
        IDLE: begin
          if (ent_valid[head]) begin
            ent_locked[head] <= 1'b1;
            mem_req_addr     <= {ent_word[head], 2'b00};
            mem_req_data     <= n_data[head];
            mem_req_mask     <= n_mask[head];
            mem_req_valid    <= 1'b1;
            state            <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            ent_valid[head]  <= 1'b0;
            ent_locked[head] <= 1'b0;
            head             <= head + 1'b1;
            mem_req_valid    <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed checks for store_write_buffer.
// Covers accept/merge/prefix, drain handshake, forwarding and reset.
module tb_store_write_buffer;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0][67:0] pkt;
  logic [1:0]       dcache_accept;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic [31:0]      mem_req_data;
  logic [3:0]       mem_req_mask;
  logic             mem_ack;
  logic [1:0][31:0] lq_addr;
  logic [1:0][3:0]  fwd_mask;
  logic [1:0][31:0] fwd_data;
  logic             empty;

  int errors = 0;
  int checks = 0;

  store_write_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .sq_dcache_packet (pkt),
    .dcache_accept    (dcache_accept),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_mask     (mem_req_mask),
    .mem_ack          (mem_ack),
    .lq_addr          (lq_addr),
    .fwd_mask         (fwd_mask),
    .fwd_data         (fwd_data),
    .empty            (empty)
  );

  always #5 clock = ~clock;

  function automatic logic [67:0] pk(
    input logic        v,
    input logic [31:0] a,
    input logic [2:0]  ss,
    input logic [31:0] d
  );
    return {v, a, ss, d};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    int n;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 32'(mem_req_valid), 32'd1);
    check({tag, "_addr"}, mem_req_addr, a);
    check({tag, "_mask"}, 32'(mem_req_mask), 32'(m));
    check({tag, "_data"}, mem_req_data, d);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    pkt     = '0;
    mem_ack = 1'b0;
    lq_addr = '0;
    pkt[0]  = pk(1'b1, 32'h100, SW, 32'h1);
    tick();
    tick();
    check("rst_acc", 32'(dcache_accept), 32'd0);
    check("rst_vld", 32'(mem_req_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_addr", mem_req_addr, 32'd0);
    pkt   = '0;
    reset = 1'b1;
    tick();

    // single word store
    pkt[0] = pk(1'b1, 32'h100, SW, 32'hDEADBEEF);
    #1;
    check("t1_acc", 32'(dcache_accept), 32'd1);
    tick();
    pkt = '0;
    check("t1_vld_early", 32'(mem_req_valid), 32'd0);
    tick();
    check("t1_vld", 32'(mem_req_valid), 32'd1);
    check("t1_addr", mem_req_addr, 32'h100);
    check("t1_mask", 32'(mem_req_mask), 32'hF);
    check("t1_data", mem_req_data, 32'hDEADBEEF);
    check("t1_busy", 32'(empty), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1_empty", 32'(empty), 32'd1);

    // same-cycle merge
    pkt[0] = pk(1'b1, 32'h201, SB, 32'hAA);
    pkt[1] = pk(1'b1, 32'h202, SH, 32'h1234);
    #1;
    check("t2_acc", 32'(dcache_accept), 32'd3);
    tick();
    pkt        = '0;
    lq_addr[0] = 32'h200;
    #1;
    check("t2_fmask", 32'(fwd_mask[0]), 32'hE);
    check("t2_fdata", fwd_data[0], 32'h1234AA00);
    drain("t2", 32'h200, 32'h1234AA00, 4'hE);
    check("t2_empty", 32'(empty), 32'd1);

    // full buffer, prefix rule, merge while full
    pkt[0] = pk(1'b1, 32'h500, SW, 32'h1);
    pkt[1] = pk(1'b1, 32'h504, SW, 32'h2);
    #1;
    check("t3_acc_a", 32'(dcache_accept), 32'd3);
    tick();
    pkt[0] = pk(1'b1, 32'h508, SW, 32'h3);
    pkt[1] = pk(1'b1, 32'h50C, SW, 32'h4);
    #1;
    check("t3_acc_b", 32'(dcache_accept), 32'd3);
    tick();
    pkt[0] = pk(1'b1, 32'h600, SW, 32'h5);
    pkt[1] = pk(1'b1, 32'h504, SB, 32'h9);
    #1;
    check("t3_prefix", 32'(dcache_accept), 32'd0);
    pkt[0] = pk(1'b1, 32'h500, SB, 32'h6);
    pkt[1] = '0;
    #1;
    check("t3_lockfull", 32'(dcache_accept), 32'd0);
    pkt[0] = '0;
    pkt[1] = pk(1'b1, 32'h509, SB, 32'h77);
    #1;
    check("t3_merge", 32'(dcache_accept), 32'd2);
    tick();
    pkt = '0;
    drain("t3_e0", 32'h500, 32'h1, 4'hF);
    drain("t3_e1", 32'h504, 32'h2, 4'hF);
    drain("t3_e2", 32'h508, 32'h7703, 4'hF);
    drain("t3_e3", 32'h50C, 32'h4, 4'hF);
    check("t3_empty", 32'(empty), 32'd1);

    // store to the locked head's word
    pkt[0] = pk(1'b1, 32'h300, SW, 32'hCAFEF00D);
    tick();
    pkt = '0;
    tick();
    check("t4_vld", 32'(mem_req_valid), 32'd1);
    pkt[0] = pk(1'b1, 32'h300, SB, 32'h55);
    #1;
    check("t4_acc", 32'(dcache_accept), 32'd1);
    tick();
    pkt        = '0;
    lq_addr[0] = 32'h300;
    #1;
    check("t4_fmask", 32'(fwd_mask[0]), 32'hF);
    check("t4_fdata", fwd_data[0], 32'hCAFEF055);
    drain("t4_a", 32'h300, 32'hCAFEF00D, 4'hF);
    drain("t4_b", 32'h300, 32'h55, 4'h1);
    check("t4_empty", 32'(empty), 32'd1);

    // forwarding from two entries of one word
    pkt[0] = pk(1'b1, 32'h400, SW, 32'h11223344);
    tick();
    pkt = '0;
    tick();
    pkt[0] = pk(1'b1, 32'h402, SB, 32'h99);
    #1;
    check("t5_acc", 32'(dcache_accept), 32'd1);
    tick();
    pkt        = '0;
    lq_addr[0] = 32'h400;
    lq_addr[1] = 32'h404;
    #1;
    check("t5_fmask0", 32'(fwd_mask[0]), 32'hF);
    check("t5_fdata0", fwd_data[0], 32'h11993344);
    check("t5_fmask1", 32'(fwd_mask[1]), 32'h0);
    check("t5_fdata1", fwd_data[1], 32'h0);
    check("t5_hold", mem_req_data, 32'h11223344);

    // reset while a request is outstanding
    reset = 1'b0;
    tick();
    check("t6_vld", 32'(mem_req_valid), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_fmask", 32'(fwd_mask[0]), 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_ack_vld", 32'(mem_req_valid), 32'd0);
    check("t6_ack_empty", 32'(empty), 32'd1);
    pkt[0] = pk(1'b1, 32'h700, SW, 32'h12345678);
    #1;
    check("t6_acc", 32'(dcache_accept), 32'd1);
    tick();
    pkt = '0;
    drain("t6", 32'h700, 32'h12345678, 4'hF);
    check("t6_empty2", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-combining buffer directly downstream of the store queue.
- Accepts up to NUM_SQ_DCACHE committed stores per cycle through the SQ→dcache packet interface and merges them into word-granular entries with byte masks.
- Drains entries oldest-first to the dcache write port through a valid/ack handshake.
- Provides combinational byte-level forwarding to the load FUs so committed-but-undrained stores stay visible.

Parameters:
- NUM_SQ_DCACHE, 2, store ports from the SQ.
- WB_LEN, 4, buffer entries; power of 2.
- NUM_FU_LOAD, 2, forwarding lookup ports.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset; state clears on a rising clock edge while reset==0.
- sq_dcache_packet  in  NUM_SQ_DCACHE x SQ_DCACHE_PACKET  {valid, addr[31:0], sign_size MEM_FUNC, data[31:0]}; data is right-aligned.
- dcache_accept  out  NUM_SQ_DCACHE  combinational per-port accept.
- mem_req_valid  out  1  registered write request.
- mem_req_addr  out  32  word address; bits [1:0]=0.
- mem_req_data  out  32  lane-aligned data.
- mem_req_mask  out  4  byte enables.
- mem_ack  in  1  request consumed this cycle.
- lq_addr  in  NUM_FU_LOAD x 32  load lookup address.
- fwd_mask  out  NUM_FU_LOAD x 4  bytes supplied by the buffer.
- fwd_data  out  NUM_FU_LOAD x 32  lane-aligned forwarded bytes; unsupplied lanes are 0.
- empty  out  1  no valid entries and no request outstanding.

Behaviour:
- Entry fields: valid, word_addr[31:2], mask[3:0], data[31:0], locked.
- Storage is a circular FIFO with head/tail pointers of log2(WB_LEN) bits plus a count of log2(WB_LEN)+1 bits.
- Lane mapping from sign_size[1:0]:
  - BYTE: mask = 1<<addr[1:0]; data shifted by 8*addr[1:0].
  - HALF: mask = addr[1] ? 4'b1100 : 4'b0011; addr[0] is ignored.
  - WORD: mask = 4'b1111.
- Accept evaluates ports in index order, combinationally from the current state.
  - Merge: port i merges if a valid, unlocked entry has an equal word_addr, or if an earlier accepted port this cycle allocated that word. No free slot is needed.
  - Allocate: otherwise port i allocates at tail if count plus allocations by lower ports < WB_LEN.
  - Prefix rule: if port i is not accepted, every port j>i is deasserted regardless of space.
  - Invalid ports are skipped and do not break the prefix.
- Merge writes only the masked bytes. Within one cycle a higher port overrides a lower port on overlapping bytes. The entry mask is ORed.
- Invariant: at most one unlocked entry per word.
  - The locked head may share a word_addr with one younger entry.
  - A store to the locked head's word always allocates a new entry.
- Drain FSM:
  - IDLE:
    - If the head entry is valid: set head.locked, load mem_req_* from head, assert mem_req_valid at the next edge, go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - mem_req_* are held stable.
    - On mem_ack: invalidate head, head++, count--, deassert mem_req_valid at the next edge, go to IDLE.
  - Minimum 2 cycles per drained entry; ack in the same cycle valid first rises is legal.
- Same-cycle pop and allocate: a slot freed by mem_ack is not visible to accept until the next cycle. Count update = +allocations − pop.
- Pointers wrap modulo WB_LEN. Full (count==WB_LEN) still allows merges into unlocked entries.
- Forwarding (combinational): for each lq_addr, scan oldest→youngest and overwrite per byte from every valid entry with a matching word_addr, so the youngest wins. Locked entries participate. Stores accepted this cycle are not visible until the next cycle.
- empty = (count==0) && !mem_req_valid.
- Reset values: every entry invalid; head=tail=count=0; FSM in IDLE. Outputs: mem_req_valid=0, mem_req_addr/data/mask=0, empty=1, dcache_accept=0. A reset asserted in REQ drops the request without waiting for ack.

Test Plan:
- Single word store: addr 0x100, WORD, data 0xDEADBEEF.
  - accept[0]=1.
  - Two cycles later: mem_req_valid=1, addr 0x100, mask 4'b1111, data 0xDEADBEEF.
  - Ack → empty=1 the next cycle.
- Same-cycle merge: port0 BYTE 0x201 data 0xAA, port1 HALF 0x202 data 0x1234.
  - Both accepted; one entry.
  - Drain: mask 4'b1110, data 0x1234AA00.
- Full with prefix: hold mem_ack=0 and fill 4 distinct words.
  - Next cycle: port0 to a new word and port1 to an existing unlocked word → accept=2'b00.
  - Port0 invalid and port1 merge → accept=2'b10.
- Locked-head hazard: drain of word 0x300 outstanding; store BYTE 0x300 data 0x55.
  - Allocates a second entry.
  - Second request after ack: addr 0x300, mask 4'b0001.
- Forwarding: entries at 0x400 are WORD 0x11223344 followed by BYTE 0x402 data 0x99; lookup 0x400.
  - fwd_mask=4'b1111, fwd_data=0x11993344.
  - Lookup 0x404 → mask 0.
- Reset mid-drain: reset=0 while in REQ.
  - Next cycle: mem_req_valid=0, empty=1.
  - A later ack is ignored; no entry is corrupted.
